// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Producer side of the instruction path. Owns the program counter, fetches
//   8-bit instructions from program memory over a req/ack handshake and hands
//   each one to the instruction register over a valid/ready handshake.
//   Inst is forced to 8'h00 (NOP) whenever no instruction is valid, because
//   the instruction register downstream loads Inst every clock.
//
// Ports
//   Clk, Rst             clock (posedge) and asynchronous active-high reset
//   Mem_Req, Mem_Addr    registered memory read request and its address
//   Mem_Ack, Mem_Data    one-cycle acknowledge with the instruction byte
//   Inst, Inst_Valid     instruction offered to the consumer
//   Inst_Ready           consumer accepts Inst this cycle
//   Jump, Jump_Addr      one-cycle redirect request and target
//   Halt                 level; stops new fetches (sampled only in IDLE)
//   PC                   address of the next fetch to issue
module instruction_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              Mem_Req,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Ack,
    input  logic [7:0]        Mem_Data,
    output logic [7:0]        Inst,
    output logic              Inst_Valid,
    input  logic              Inst_Ready,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] Jump_Addr,
    input  logic              Halt,
    output logic [ADDR_W-1:0] PC
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DELIVER,
        HALTED
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] pc_n;
    logic              mem_req_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        inst_n;
    logic              inst_valid_n;
    // Set when a jump arrives while a fetch is outstanding; the returning
    // data belongs to the old instruction stream and must be discarded.
    logic              flush;
    logic              flush_n;
    logic [ADDR_W-1:0] issue_addr;

    // A jump in IDLE redirects the fetch issued in that same cycle.
    assign issue_addr = Jump ? Jump_Addr : PC;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            PC         <= RESET_PC;
            Mem_Req    <= 1'b0;
            Mem_Addr   <= '0;
            Inst       <= 8'h00;
            Inst_Valid <= 1'b0;
            flush      <= 1'b0;
        end else begin
            state      <= state_n;
            PC         <= pc_n;
            Mem_Req    <= mem_req_n;
            Mem_Addr   <= mem_addr_n;
            Inst       <= inst_n;
            Inst_Valid <= inst_valid_n;
            flush      <= flush_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = Jump ? Jump_Addr : PC;
        mem_req_n    = Mem_Req;
        mem_addr_n   = Mem_Addr;
        inst_n       = Inst;
        inst_valid_n = Inst_Valid;
        flush_n      = flush;

        case (state)
            IDLE: begin
                if (Halt) begin
                    state_n = HALTED;
                end else begin
                    mem_req_n  = 1'b1;
                    mem_addr_n = issue_addr;
                    pc_n       = issue_addr + ADDR_W'(1);
                    state_n    = FETCH;
                end
            end

            FETCH: begin
                if (Mem_Ack) begin
                    mem_req_n = 1'b0;
                    if (flush || Jump) begin
                        // Stale data from before a redirect: drop it and
                        // restart from the new PC.
                        flush_n = 1'b0;
                        state_n = IDLE;
                    end else begin
                        inst_n       = Mem_Data;
                        inst_valid_n = 1'b1;
                        state_n      = DELIVER;
                    end
                end else if (Jump) begin
                    // The request stays outstanding; only its data is void.
                    flush_n = 1'b1;
                end
            end

            DELIVER: begin
                // A transfer and a drop-on-jump leave the same register
                // state; in the transfer case the consumer has already
                // sampled Inst on this edge.
                if (Inst_Ready || Jump) begin
                    inst_valid_n = 1'b0;
                    inst_n       = 8'h00;
                    state_n      = IDLE;
                end
            end

            HALTED: begin
                mem_req_n    = 1'b0;
                inst_valid_n = 1'b0;
                inst_n       = 8'h00;
                if (!Halt) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit. Two instances share all inputs: one
// with RESET_PC=0, one with RESET_PC=8'hFE for the wrap-around scenario.
// sel chooses which instance the tasks and the memory responder look at.
module tb_instruction_fetch_unit;

    logic       Clk;
    logic       Rst;
    logic       Mem_Ack;
    logic [7:0] Mem_Data;
    logic       Inst_Ready;
    logic       Jump;
    logic [7:0] Jump_Addr;
    logic       Halt;

    logic       req0, req1, v0, v1;
    logic [7:0] addr0, addr1, inst0, inst1, pc0, pc1;

    logic       sel;
    logic       Mem_Req, Inst_Valid;
    logic [7:0] Mem_Addr, Inst, PC;

    assign Mem_Req    = sel ? req1  : req0;
    assign Mem_Addr   = sel ? addr1 : addr0;
    assign Inst       = sel ? inst1 : inst0;
    assign Inst_Valid = sel ? v1    : v0;
    assign PC         = sel ? pc1   : pc0;

    instruction_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut0 (
        .Clk(Clk), .Rst(Rst), .Mem_Req(req0), .Mem_Addr(addr0),
        .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data), .Inst(inst0), .Inst_Valid(v0),
        .Inst_Ready(Inst_Ready), .Jump(Jump), .Jump_Addr(Jump_Addr),
        .Halt(Halt), .PC(pc0)
    );

    instruction_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFE)) dut1 (
        .Clk(Clk), .Rst(Rst), .Mem_Req(req1), .Mem_Addr(addr1),
        .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data), .Inst(inst1), .Inst_Valid(v1),
        .Inst_Ready(Inst_Ready), .Jump(Jump), .Jump_Addr(Jump_Addr),
        .Halt(Halt), .PC(pc1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp;
    int n_fail;

    // Program memory model and responder.
    logic [7:0] mem [256];
    logic       mem_en;
    logic       man_ack;
    logic [7:0] man_data;
    int         ack_lat;
    logic       rand_lat;
    int         wait_cnt;
    int         lat_cur;

    // Runs 2 time units after the falling edge so it sees the inputs the
    // tasks set on that edge; acks after lat_cur full cycles of Mem_Req.
    always @(negedge Clk) begin
        #2;
        if (!Rst && mem_en && Mem_Req) begin
            if (wait_cnt >= lat_cur) begin
                Mem_Ack  = 1'b1;
                Mem_Data = mem[Mem_Addr];
                wait_cnt = 0;
            end else begin
                Mem_Ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            Mem_Ack  = man_ack;
            Mem_Data = man_data;
            wait_cnt = 0;
            lat_cur  = rand_lat ? int'($urandom_range(0, 3)) : ack_lat;
        end
    end

    task automatic fill_mem_ramp();
        for (int i = 0; i < 256; i++) mem[i] = 8'(16 + i);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1; Jump = 1'b0; Halt = 1'b0; Inst_Ready = 1'b0;
        man_ack = 1'b0; Jump_Addr = 8'h00;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic wait_for(input bit want_valid, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (want_valid ? Inst_Valid : Mem_Req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        n_cmp++; if (Mem_Req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", Mem_Req); end
        n_cmp++; if (Mem_Addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", Mem_Addr); end
        n_cmp++; if (Inst !== 8'h00) begin n_fail++; $display("FAIL reset_inst: got %h expected 00", Inst); end
        n_cmp++; if (Inst_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", Inst_Valid); end
        n_cmp++; if (PC !== 8'h00) begin n_fail++; $display("FAIL reset_pc0: got %h expected 00", PC); end
        sel = 1'b1;
        #1;
        n_cmp++; if (PC !== 8'hFE) begin n_fail++; $display("FAIL reset_pc1: got %h expected fe", PC); end
        n_cmp++; if (Mem_Addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr1: got %h expected 00", Mem_Addr); end
        sel = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_stream();
        int   issue_cnt, deliv_cnt, last_c;
        logic prev_req;
        sel = 1'b0; mem_en = 1'b1; rand_lat = 1'b0; ack_lat = 0;
        fill_mem_ramp();
        do_reset();
        Inst_Ready = 1'b1;
        issue_cnt = 0; deliv_cnt = 0; last_c = 0; prev_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            if (Mem_Req && !prev_req) begin
                n_cmp++; if (Mem_Addr !== 8'(issue_cnt)) begin n_fail++; $display("FAIL stream_addr: got %h expected %h", Mem_Addr, 8'(issue_cnt)); end
                issue_cnt++;
            end
            if (Inst_Valid) begin
                n_cmp++; if (Inst !== 8'(16 + deliv_cnt)) begin n_fail++; $display("FAIL stream_inst: got %h expected %h", Inst, 8'(16 + deliv_cnt)); end
                if (deliv_cnt > 0) begin
                    n_cmp++; if (c - last_c !== 3) begin n_fail++; $display("FAIL stream_spacing: got %0d expected 3", c - last_c); end
                end
                last_c = c;
                deliv_cnt++;
            end else begin
                n_cmp++; if (Inst !== 8'h00) begin n_fail++; $display("FAIL stream_nop: got %h expected 00", Inst); end
            end
            prev_req = Mem_Req;
        end
        n_cmp++; if (issue_cnt !== 4) begin n_fail++; $display("FAIL stream_issues: got %0d expected 4", issue_cnt); end
        n_cmp++; if (deliv_cnt !== 4) begin n_fail++; $display("FAIL stream_delivered: got %0d expected 4", deliv_cnt); end
    endtask

    task automatic test_stall();
        bit ok;
        sel = 1'b0; mem_en = 1'b1; rand_lat = 1'b0; ack_lat = 0;
        fill_mem_ramp();
        do_reset();
        wait_for(1'b1, 10, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no valid expected valid"); end
        n_cmp++; if (Inst !== 8'h10) begin n_fail++; $display("FAIL stall_first: got %h expected 10", Inst); end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            n_cmp++; if (Inst_Valid !== 1'b1 || Inst !== 8'h10) begin n_fail++; $display("FAIL stall_hold: got %b/%h expected 1/10", Inst_Valid, Inst); end
            n_cmp++; if (Mem_Req !== 1'b0) begin n_fail++; $display("FAIL stall_noreq: got %b expected 0", Mem_Req); end
        end
        Inst_Ready = 1'b1;
        @(negedge Clk);
        n_cmp++; if (Inst_Valid !== 1'b0 || Inst !== 8'h00) begin n_fail++; $display("FAIL stall_xfer: got %b/%h expected 0/00", Inst_Valid, Inst); end
        @(negedge Clk);
        n_cmp++; if (Mem_Req !== 1'b1 || Mem_Addr !== 8'h01) begin n_fail++; $display("FAIL stall_next: got %b/%h expected 1/01", Mem_Req, Mem_Addr); end
    endtask

    task automatic test_jump_fetch();
        bit ok;
        sel = 1'b0; mem_en = 1'b1; rand_lat = 1'b0; ack_lat = 4;
        fill_mem_ramp();
        do_reset();
        Inst_Ready = 1'b1;
        @(negedge Clk);
        n_cmp++; if (Mem_Req !== 1'b1 || Mem_Addr !== 8'h00) begin n_fail++; $display("FAIL jf_issue: got %b/%h expected 1/00", Mem_Req, Mem_Addr); end
        @(negedge Clk);
        Jump = 1'b1; Jump_Addr = 8'h40;
        @(negedge Clk);
        Jump = 1'b0;
        n_cmp++; if (PC !== 8'h40) begin n_fail++; $display("FAIL jf_pc: got %h expected 40", PC); end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (Inst_Valid !== 1'b0) begin n_fail++; $display("FAIL jf_novalid: got %b expected 0", Inst_Valid); end
            if (!Mem_Req) begin ok = 1'b1; break; end
            n_cmp++; if (Mem_Addr !== 8'h00) begin n_fail++; $display("FAIL jf_addr_hold: got %h expected 00", Mem_Addr); end
            @(negedge Clk);
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL jf_timeout: got req held expected ack"); end
        @(negedge Clk);
        n_cmp++; if (Mem_Req !== 1'b1 || Mem_Addr !== 8'h40) begin n_fail++; $display("FAIL jf_redirect: got %b/%h expected 1/40", Mem_Req, Mem_Addr); end
        n_cmp++; if (PC !== 8'h41) begin n_fail++; $display("FAIL jf_pc_next: got %h expected 41", PC); end
        n_cmp++; if (Inst_Valid !== 1'b0) begin n_fail++; $display("FAIL jf_dropped: got %b expected 0", Inst_Valid); end
    endtask

    task automatic test_jump_deliver();
        bit ok;
        sel = 1'b0; mem_en = 1'b1; rand_lat = 1'b0; ack_lat = 0;
        fill_mem_ramp();
        // Jump while the consumer stalls: instruction dropped.
        do_reset();
        wait_for(1'b1, 10, ok);
        n_cmp++; if (!ok || Inst !== 8'h10) begin n_fail++; $display("FAIL jd_valid: got %b/%h expected 1/10", ok, Inst); end
        Jump = 1'b1; Jump_Addr = 8'h80;
        @(negedge Clk);
        Jump = 1'b0;
        n_cmp++; if (Inst_Valid !== 1'b0 || Inst !== 8'h00) begin n_fail++; $display("FAIL jd_drop: got %b/%h expected 0/00", Inst_Valid, Inst); end
        n_cmp++; if (PC !== 8'h80) begin n_fail++; $display("FAIL jd_pc: got %h expected 80", PC); end
        @(negedge Clk);
        n_cmp++; if (Mem_Req !== 1'b1 || Mem_Addr !== 8'h80) begin n_fail++; $display("FAIL jd_req: got %b/%h expected 1/80", Mem_Req, Mem_Addr); end
        n_cmp++; if (PC !== 8'h81) begin n_fail++; $display("FAIL jd_pc_next: got %h expected 81", PC); end
        // Jump in the same cycle as a transfer.
        do_reset();
        Inst_Ready = 1'b1;
        wait_for(1'b1, 10, ok);
        n_cmp++; if (!ok || Inst !== 8'h10) begin n_fail++; $display("FAIL jdx_valid: got %b/%h expected 1/10", ok, Inst); end
        Jump = 1'b1; Jump_Addr = 8'h80;
        @(negedge Clk);
        Jump = 1'b0;
        n_cmp++; if (Inst_Valid !== 1'b0 || PC !== 8'h80) begin n_fail++; $display("FAIL jdx_after: got %b/%h expected 0/80", Inst_Valid, PC); end
        @(negedge Clk);
        n_cmp++; if (Mem_Req !== 1'b1 || Mem_Addr !== 8'h80) begin n_fail++; $display("FAIL jdx_req: got %b/%h expected 1/80", Mem_Req, Mem_Addr); end
    endtask

    task automatic test_wrap_halt();
        bit ok;
        sel = 1'b1; mem_en = 1'b1; rand_lat = 1'b0; ack_lat = 2;
        fill_mem_ramp();
        do_reset();
        n_cmp++; if (PC !== 8'hFE) begin n_fail++; $display("FAIL wh_pc_reset: got %h expected fe", PC); end
        Inst_Ready = 1'b1;
        wait_for(1'b0, 10, ok);
        n_cmp++; if (!ok || Mem_Addr !== 8'hFE) begin n_fail++; $display("FAIL wh_addr_fe: got %b/%h expected 1/fe", ok, Mem_Addr); end
        wait_for(1'b1, 10, ok);
        n_cmp++; if (!ok || Inst !== 8'h0E) begin n_fail++; $display("FAIL wh_inst_fe: got %b/%h expected 1/0e", ok, Inst); end
        wait_for(1'b0, 10, ok);
        n_cmp++; if (!ok || Mem_Addr !== 8'hFF) begin n_fail++; $display("FAIL wh_addr_ff: got %b/%h expected 1/ff", ok, Mem_Addr); end
        Halt = 1'b1;
        wait_for(1'b1, 10, ok);
        n_cmp++; if (!ok || Inst !== 8'h0F) begin n_fail++; $display("FAIL wh_inst_ff: got %b/%h expected 1/0f", ok, Inst); end
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            n_cmp++; if (Mem_Req !== 1'b0 || Inst_Valid !== 1'b0) begin n_fail++; $display("FAIL wh_halted: got %b/%b expected 0/0", Mem_Req, Inst_Valid); end
        end
        n_cmp++; if (PC !== 8'h00) begin n_fail++; $display("FAIL wh_pc_wrap: got %h expected 00", PC); end
        Halt = 1'b0;
        wait_for(1'b0, 6, ok);
        n_cmp++; if (!ok || Mem_Addr !== 8'h00) begin n_fail++; $display("FAIL wh_resume: got %b/%h expected 1/00", ok, Mem_Addr); end
        wait_for(1'b1, 10, ok);
        n_cmp++; if (!ok || Inst !== 8'h10) begin n_fail++; $display("FAIL wh_inst_00: got %b/%h expected 1/10", ok, Inst); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        sel = 1'b0; mem_en = 1'b0; rand_lat = 1'b0; ack_lat = 0;
        fill_mem_ramp();
        man_data = 8'hAA;
        do_reset();
        wait_for(1'b0, 5, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmf_req: got none expected request"); end
        @(negedge Clk);
        #3;
        Rst = 1'b1;
        #1;
        n_cmp++; if (Mem_Req !== 1'b0 || PC !== 8'h00 || Mem_Addr !== 8'h00) begin n_fail++; $display("FAIL rmf_async: got %b/%h/%h expected 0/00/00", Mem_Req, PC, Mem_Addr); end
        @(negedge Clk);
        Rst = 1'b0;
        man_ack = 1'b1;
        @(negedge Clk);
        man_ack = 1'b0;
        n_cmp++; if (Mem_Req !== 1'b1 || Mem_Addr !== 8'h00) begin n_fail++; $display("FAIL rmf_restart: got %b/%h expected 1/00", Mem_Req, Mem_Addr); end
        n_cmp++; if (Inst_Valid !== 1'b0 || Inst !== 8'h00) begin n_fail++; $display("FAIL rmf_stale: got %b/%h expected 0/00", Inst_Valid, Inst); end
        mem_en = 1'b1;
        wait_for(1'b1, 10, ok);
        n_cmp++; if (!ok || Inst !== 8'h10) begin n_fail++; $display("FAIL rmf_deliver: got %b/%h expected 1/10", ok, Inst); end
    endtask

    // Transaction-level model: fetch addresses run sequentially from
    // RESET_PC, and the consumer must receive mem[] of those addresses in
    // order, whatever the ack latency, consumer stalls or halts.
    task automatic test_random();
        logic [7:0] exp_issue;
        logic [7:0] exp_q[$];
        logic [7:0] prev_inst, front;
        logic       prev_valid, prev_ready, prev_req;
        int         delivered;
        sel = 1'b0; mem_en = 1'b1; rand_lat = 1'b1; ack_lat = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        exp_issue = 8'h00; prev_valid = 1'b0; prev_ready = 1'b0; prev_req = 1'b0;
        prev_inst = 8'h00; delivered = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge Clk);
            if (Mem_Req && !prev_req) begin
                n_cmp++; if (Mem_Addr !== exp_issue) begin n_fail++; $display("FAIL rnd_addr: got %h expected %h", Mem_Addr, exp_issue); end
                exp_q.push_back(mem[exp_issue]);
                exp_issue = exp_issue + 8'h01;
            end
            n_cmp++; if (PC !== exp_issue) begin n_fail++; $display("FAIL rnd_pc: got %h expected %h", PC, exp_issue); end
            if (!Inst_Valid) begin
                n_cmp++; if (Inst !== 8'h00) begin n_fail++; $display("FAIL rnd_nop: got %h expected 00", Inst); end
            end
            if (prev_valid && !prev_ready) begin
                n_cmp++; if (Inst_Valid !== 1'b1 || Inst !== prev_inst) begin n_fail++; $display("FAIL rnd_hold: got %b/%h expected 1/%h", Inst_Valid, Inst, prev_inst); end
            end
            Inst_Ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 19) == 0) Halt = ~Halt;
            if (Inst_Valid && Inst_Ready) begin
                front = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_cmp++; if (Inst !== front) begin n_fail++; $display("FAIL rnd_inst: got %h expected %h", Inst, front); end
                delivered++;
            end
            prev_valid = Inst_Valid; prev_ready = Inst_Ready;
            prev_inst = Inst; prev_req = Mem_Req;
        end
        n_cmp++; if (delivered < 20) begin n_fail++; $display("FAIL rnd_progress: got %0d expected at least 20", delivered); end
        Halt = 1'b0;
        rand_lat = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        Rst = 1'b1; Jump = 1'b0; Jump_Addr = 8'h00; Halt = 1'b0; Inst_Ready = 1'b0;
        Mem_Ack = 1'b0; Mem_Data = 8'h00; man_ack = 1'b0; man_data = 8'h00;
        mem_en = 1'b1; ack_lat = 0; rand_lat = 1'b0; wait_cnt = 0; lat_cur = 0;
        sel = 1'b0;
        fill_mem_ramp();
        test_reset();
        test_stream();
        test_stall();
        test_jump_fetch();
        test_jump_deliver();
        test_wrap_halt();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer side of the instruction path. Holds the program counter, reads 8-bit instructions from program memory over a req/ack handshake, and presents each one on Inst with a valid/ready handshake.
- The instruction register loads Inst every clock and splits it into OpCode[7:4] and Operand[3:0]. This block therefore drives Inst = 8'h00 (NOP) whenever no instruction is valid.
- Supports jump redirect and halt.

Parameters:
ADDR_W, 8, program counter and memory address width
RESET_PC, 0, PC value loaded on reset

Ports:
Clk  in  1  clock; all state on posedge
Rst  in  1  asynchronous active-high reset
Mem_Req  out  1  memory read request, registered
Mem_Addr  out  ADDR_W  address of outstanding request, registered
Mem_Ack  in  1  one-cycle pulse; Mem_Data valid in the same cycle
Mem_Data  in  8  instruction byte from program memory
Inst  out  8  instruction to instruction register; 8'h00 when Inst_Valid=0
Inst_Valid  out  1  Inst holds a fetched instruction
Inst_Ready  in  1  consumer accepts Inst this cycle
Jump  in  1  one-cycle redirect request
Jump_Addr  in  ADDR_W  redirect target
Halt  in  1  level; suppresses new fetches
PC  out  ADDR_W  address of next fetch to issue

Behaviour:
- Reset (async, Rst=1): state=IDLE, PC=RESET_PC, Mem_Req=0, Mem_Addr=0, Inst=8'h00, Inst_Valid=0, Flush=0.
- Transfers: a transfer occurs on an edge where Inst_Valid&&Inst_Ready. A memory response occurs on an edge where Mem_Req&&Mem_Ack.
- IDLE:
  - Halt=1 -> HALTED.
  - Otherwise: Mem_Req<=1, Mem_Addr<=PC, PC<=PC+1 (wraps modulo 2^ADDR_W), go to FETCH.
- FETCH:
  - Mem_Req and Mem_Addr are held stable until Mem_Ack.
  - On Mem_Ack with Flush=0: Mem_Req<=0, Inst<=Mem_Data, Inst_Valid<=1, go to DELIVER.
  - On Mem_Ack with Flush=1: data discarded, Mem_Req<=0, Flush<=0, go to IDLE.
- DELIVER:
  - Inst and Inst_Valid are held stable until a transfer.
  - On a transfer: Inst_Valid<=0, Inst<=8'h00, go to IDLE.
- HALTED:
  - Mem_Req=0, Inst_Valid=0.
  - Halt=0 -> IDLE.
- Jump (takes effect in any state): PC<=Jump_Addr. Additionally, per state:
  - IDLE: the issue in that same cycle uses Jump_Addr. Mem_Addr<=Jump_Addr, PC<=Jump_Addr+1.
  - FETCH without Mem_Ack: Flush<=1. The outstanding request is not withdrawn.
  - FETCH with Mem_Ack: data discarded, go to IDLE, Flush<=0.
  - DELIVER without Inst_Ready: instruction dropped, Inst_Valid<=0, Inst<=8'h00, go to IDLE.
  - DELIVER with Inst_Ready: the transfer counts as completed (the consumer already sampled Inst); go to IDLE with the new PC.
  - HALTED: PC updated, remain HALTED.
  - A second Jump while Flush=1: PC is overwritten, Flush stays 1.
- Halt is sampled only in IDLE. An in-flight fetch and a pending delivery always complete.
- Throughput: with Mem_Ack in the first FETCH cycle and Inst_Ready tied high, one instruction every 3 cycles.
- Rst asserted mid-FETCH abandons the request immediately (Mem_Req=0). A late Mem_Ack is ignored, because Mem_Ack is only honoured in FETCH.

Test Plan:
- Reset, Halt=0, memory acks one cycle after Mem_Req with data = 8'h10+addr, Inst_Ready=1 -> Mem_Addr sequence 0,1,2,3. Inst shows 8'h10,8'h11,8'h12,8'h13 with Inst_Valid, one every 3 cycles. Inst=8'h00 between.
- Inst_Ready=0 for 5 cycles with Inst=8'h10 valid -> Inst and Inst_Valid stable. No new Mem_Req. Transfer on first Inst_Ready=1, then Mem_Addr=1 issued.
- Ack delayed 4 cycles, Jump with Jump_Addr=8'h40 in 2nd FETCH cycle -> Mem_Addr stays 0 until ack. Ack data is not delivered (Inst_Valid stays 0). Next Mem_Addr=8'h40, PC=8'h41.
- DELIVER with Inst_Ready=0, Jump to 8'h80 -> Inst_Valid=0 next cycle. Next request at 8'h80. Also: Jump and Inst_Ready in the same cycle -> transfer completed, next request at 8'h80.
- RESET_PC=8'hFE -> fetches 8'hFE, 8'hFF, 8'h00 (wrap). Halt=1 during the fetch of 8'hFF -> 8'hFF is delivered, then no Mem_Req until Halt=0, then fetch at 8'h00.
- Rst pulsed mid-FETCH, then Mem_Ack pulse -> Mem_Req=0 and PC=RESET_PC immediately. Stale ack ignored. Fetch restarts at RESET_PC.
